ahb_fanout_n: RTL and testbench
===============================

AHB_FANOUT_N -- requirements
Module: ahb_fanout_n

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 3, giving the number of downstream AHB-Lite ports, legal range 1..8.
REQ-002 The block SHALL have parameter ADDR_W, default 31, giving the haddr width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the hwdata/hrdata width.
REQ-004 The block SHALL have parameters BASE and MASK, each N_PORTS*ADDR_W bits packed, with slice i being the decode base and mask of port i; defaults are 0x0000_0000, 0x1000_0000 and 0x2000_0000, each with mask 0x7000_0000.
REQ-005 The block SHALL have port clock, input, 1 bit, the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-007 The block SHALL have ports auto_in_hready (in, 1), auto_in_htrans (in, 2), auto_in_hsize (in, 3), auto_in_hwrite (in, 1), auto_in_haddr (in, ADDR_W) and auto_in_hwdata (in, DATA_W), forming the master address/data phase.
REQ-008 The block SHALL have ports auto_in_hreadyout (out, 1), auto_in_hresp (out, 1) and auto_in_hrdata (out, DATA_W), forming the master response.
REQ-009 The block SHALL have outputs auto_out_hsel (N_PORTS), auto_out_hready (N_PORTS), auto_out_htrans (2*N_PORTS), auto_out_hsize (3*N_PORTS), auto_out_hwrite (N_PORTS), auto_out_haddr (ADDR_W*N_PORTS) and auto_out_hwdata (DATA_W*N_PORTS), one slice per port.
REQ-010 The block SHALL have inputs auto_out_hreadyout (N_PORTS), auto_out_hresp (N_PORTS) and auto_out_hrdata (DATA_W*N_PORTS), one slice per port.
REQ-011 The block SHALL have output err_count, 8 bits, a saturating count of default-slave errors.

Function
REQ-012 Port i SHALL hit when (auto_in_haddr & MASK_i) == BASE_i; on overlap the lowest index SHALL win; no hit SHALL select the default slave.
REQ-013 auto_out_hsel[i] SHALL be 1 only when htrans[1]=1 and port i wins the decode, and SHALL be combinational.
REQ-014 auto_out_htrans slice i SHALL equal auto_in_htrans when hsel[i]=1 and IDLE (00) otherwise.
REQ-015 hsize, hwrite, haddr, hwdata and hready SHALL be broadcast unchanged to every port.
REQ-016 Data-phase owner register dsel, one-hot over N_PORTS+1 entries (last entry = default slave) or all-zero, SHALL load the decode result when auto_in_hready=1 and hold otherwise.
REQ-017 dsel SHALL be loaded all-zero when htrans is IDLE or BUSY at a sampled address phase.
REQ-018 auto_in_hreadyout, hresp and hrdata SHALL be muxed from the port named by dsel.
REQ-019 When dsel is all-zero, the block SHALL drive hreadyout=1, hresp=0 and hrdata=0.
REQ-020 While the default slave owns the data phase, hrdata SHALL be 0.
REQ-021 The default-slave FSM SHALL have states IDLE, ERR1 and ERR2.
REQ-022 The FSM SHALL go IDLE->ERR1 when a miss is sampled with hready=1.
REQ-023 ERR1 SHALL drive hreadyout=0, hresp=1 and SHALL go to ERR2 unconditionally.
REQ-024 ERR2 SHALL drive hreadyout=1, hresp=1; it SHALL go to ERR1 if a new miss is sampled that cycle and to IDLE otherwise.
REQ-025 A hit sampled in ERR2 SHALL transfer ownership to the hit port in the next cycle, with the FSM returning to IDLE.
REQ-026 err_count SHALL increment by 1 on each ERR1 entry and SHALL saturate at 0xFF.
REQ-027 Response latency through the block SHALL be zero cycles (combinational mux); only dsel, the FSM state and err_count are registered.
REQ-028 The block SHALL NOT decode or sample auto_in_haddr while auto_in_hready=0.

Reset
REQ-029 While reset=0, dsel SHALL be all-zero, the FSM SHALL be IDLE and err_count SHALL be 0, taking effect asynchronously.
REQ-030 During and immediately after reset, auto_in_hreadyout SHALL be 1, hresp 0 and hrdata 0.
REQ-031 Reset asserted mid-transfer, including in ERR1 or ERR2, SHALL abandon the transfer with no residual state.
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL require no cycles after deassertion before accepting an address phase.

Verification
REQ-033 The bench SHALL cover: NONSEQ read at 0x1000_0040, port1 hrdata=0xCAFE_F00D, hreadyout=1 -> hsel=3'b010, master sees 0xCAFE_F00D one cycle later with hresp=0.
REQ-034 The bench SHALL cover: read at 0x2000_0000 with port2 holding hreadyout=0 for 3 cycles -> master hreadyout=0 for exactly 3 cycles, no dsel change, haddr not re-decoded.
REQ-035 The bench SHALL cover: NONSEQ at 0x3000_0000 -> hsel=0, next cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1, then IDLE, with err_count=1.
REQ-036 The bench SHALL cover: back-to-back misses where the second is accepted in ERR2 -> ERR1 re-entered immediately and err_count=2; after 300 misses err_count=0xFF.
REQ-037 The bench SHALL cover: reset=0 asserted in ERR1 -> same-cycle hreadyout=1, hresp=0, err_count=0; first transfer after release to 0x0000_0010 routes to port0.
REQ-038 The bench SHALL cover: N_PORTS=1 build, and overlapping BASE/MASK with port0 and port1 both matching -> only hsel[0]=1.

Source files
------------

// File: rtl/ahb_fanout_n.sv
// AHB-Lite one-master to N-slave fanout with address decode, data-phase response
// mux and a built-in default slave that answers unmapped addresses with a two-cycle ERROR.
module ahb_fanout_n #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 31,
  parameter int DATA_W  = 32,
  parameter logic [N_PORTS*ADDR_W-1:0] BASE = {ADDR_W'(32'h2000_0000), ADDR_W'(32'h1000_0000),
                                               ADDR_W'(32'h0000_0000)},
  parameter logic [N_PORTS*ADDR_W-1:0] MASK = {ADDR_W'(32'h7000_0000), ADDR_W'(32'h7000_0000),
                                               ADDR_W'(32'h7000_0000)}
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       auto_in_hready,
  input  logic [1:0]                 auto_in_htrans,
  input  logic [2:0]                 auto_in_hsize,
  input  logic                       auto_in_hwrite,
  input  logic [ADDR_W-1:0]          auto_in_haddr,
  input  logic [DATA_W-1:0]          auto_in_hwdata,
  output logic                       auto_in_hreadyout,
  output logic                       auto_in_hresp,
  output logic [DATA_W-1:0]          auto_in_hrdata,
  output logic [N_PORTS-1:0]         auto_out_hsel,
  output logic [N_PORTS-1:0]         auto_out_hready,
  output logic [2*N_PORTS-1:0]       auto_out_htrans,
  output logic [3*N_PORTS-1:0]       auto_out_hsize,
  output logic [N_PORTS-1:0]         auto_out_hwrite,
  output logic [ADDR_W*N_PORTS-1:0]  auto_out_haddr,
  output logic [DATA_W*N_PORTS-1:0]  auto_out_hwdata,
  input  logic [N_PORTS-1:0]         auto_out_hreadyout,
  input  logic [N_PORTS-1:0]         auto_out_hresp,
  input  logic [DATA_W*N_PORTS-1:0]  auto_out_hrdata,
  output logic [7:0]                 err_count,
  output logic [1:0]                 dbg_state
);

  // Handshake: an address phase is accepted only on a clock edge where auto_in_hready=1
  // and htrans[1]=1; the data phase that follows completes on the first cycle the owning
  // slave drives hreadyout=1. Nothing is decoded or sampled while auto_in_hready=0.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ERR1 = 2'd1, S_ERR2 = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [N_PORTS:0]   dsel_q, dsel_d;
  logic [7:0]         err_count_q, err_count_d;
  logic [N_PORTS-1:0] hit_oh;
  logic               hit_any;
  logic               xfer;
  logic               miss;
  logic               err_enter;

  // Lowest-index port wins when several windows overlap.
  always_comb begin
    hit_oh  = '0;
    hit_any = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!hit_any && ((auto_in_haddr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  assign xfer = auto_in_htrans[1];
  assign miss = xfer & ~hit_any;

  assign auto_out_hsel   = xfer ? hit_oh : '0;
  assign auto_out_hready = {N_PORTS{auto_in_hready}};
  assign auto_out_hsize  = {N_PORTS{auto_in_hsize}};
  assign auto_out_hwrite = {N_PORTS{auto_in_hwrite}};
  assign auto_out_haddr  = {N_PORTS{auto_in_haddr}};
  assign auto_out_hwdata = {N_PORTS{auto_in_hwdata}};

  for (genvar g = 0; g < N_PORTS; g++) begin : g_htrans
    assign auto_out_htrans[2*g +: 2] = auto_out_hsel[g] ? auto_in_htrans : 2'b00;
  end

  always_comb begin
    dsel_d = dsel_q;
    if (auto_in_hready) begin
      if (!xfer) begin
        dsel_d = '0;
      end else if (hit_any) begin
        dsel_d = {1'b0, hit_oh};
      end else begin
        dsel_d          = '0;
        dsel_d[N_PORTS] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (auto_in_hready && miss) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = (auto_in_hready && miss) ? S_ERR1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign err_enter   = (state_d == S_ERR1) && (state_q != S_ERR1);
  assign err_count_d = (err_enter && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dsel_q      <= '0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      dsel_q      <= dsel_d;
      err_count_q <= err_count_d;
    end
  end

  // Idle bus answers OKAY/ready; the default slave never returns read data.
  always_comb begin
    auto_in_hreadyout = 1'b1;
    auto_in_hresp     = 1'b0;
    auto_in_hrdata    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dsel_q[i]) begin
        auto_in_hreadyout = auto_out_hreadyout[i];
        auto_in_hresp     = auto_out_hresp[i];
        auto_in_hrdata    = auto_out_hrdata[i*DATA_W +: DATA_W];
      end
    end
    if (dsel_q[N_PORTS]) begin
      auto_in_hreadyout = (state_q != S_ERR1);
      auto_in_hresp     = (state_q != S_IDLE);
      auto_in_hrdata    = '0;
    end
  end

  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_fanout_n.sv
// Bench for ahb_fanout_n: directed scenarios plus randomized traffic checked against a
// transaction-level model of ownership and default-slave error responses.
module tb_ahb_fanout_n;
  localparam int NP = 3;
  localparam int AW = 31;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          hready, hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;

  logic               m_hreadyout, m_hresp;
  logic [DW-1:0]      m_hrdata;
  logic [NP-1:0]      o_hsel, o_hready, o_hwrite;
  logic [2*NP-1:0]    o_htrans;
  logic [3*NP-1:0]    o_hsize;
  logic [AW*NP-1:0]   o_haddr;
  logic [DW*NP-1:0]   o_hwdata;
  logic [NP-1:0]      s_rdy, s_resp;
  logic [DW*NP-1:0]   s_rdata;
  logic [7:0]         m_err;
  logic [1:0]         m_dbg;

  ahb_fanout_n dut (
    .clock(clock), .reset(reset),
    .auto_in_hready(hready), .auto_in_htrans(htrans), .auto_in_hsize(hsize),
    .auto_in_hwrite(hwrite), .auto_in_haddr(haddr), .auto_in_hwdata(hwdata),
    .auto_in_hreadyout(m_hreadyout), .auto_in_hresp(m_hresp), .auto_in_hrdata(m_hrdata),
    .auto_out_hsel(o_hsel), .auto_out_hready(o_hready), .auto_out_htrans(o_htrans),
    .auto_out_hsize(o_hsize), .auto_out_hwrite(o_hwrite), .auto_out_haddr(o_haddr),
    .auto_out_hwdata(o_hwdata), .auto_out_hreadyout(s_rdy), .auto_out_hresp(s_resp),
    .auto_out_hrdata(s_rdata), .err_count(m_err), .dbg_state(m_dbg)
  );

  // Two-port build with overlapping windows: both match 0x1000_0040.
  logic           ov_hreadyout, ov_hresp;
  logic [DW-1:0]  ov_hrdata;
  logic [1:0]     ov_hsel, ov_hready, ov_hwrite, ov_rdy, ov_resp;
  logic [3:0]     ov_htrans;
  logic [5:0]     ov_hsize;
  logic [2*AW-1:0] ov_haddr;
  logic [2*DW-1:0] ov_hwdata, ov_rdata;
  logic [7:0]     ov_err;
  logic [1:0]     ov_dbg;

  ahb_fanout_n #(.N_PORTS(2), .ADDR_W(AW), .DATA_W(DW),
    .BASE({31'h1000_0000, 31'h1000_0000}), .MASK({31'h7F00_0000, 31'h7000_0000})) dut_ov (
    .clock(clock), .reset(reset),
    .auto_in_hready(hready), .auto_in_htrans(htrans), .auto_in_hsize(hsize),
    .auto_in_hwrite(hwrite), .auto_in_haddr(haddr), .auto_in_hwdata(hwdata),
    .auto_in_hreadyout(ov_hreadyout), .auto_in_hresp(ov_hresp), .auto_in_hrdata(ov_hrdata),
    .auto_out_hsel(ov_hsel), .auto_out_hready(ov_hready), .auto_out_htrans(ov_htrans),
    .auto_out_hsize(ov_hsize), .auto_out_hwrite(ov_hwrite), .auto_out_haddr(ov_haddr),
    .auto_out_hwdata(ov_hwdata), .auto_out_hreadyout(ov_rdy), .auto_out_hresp(ov_resp),
    .auto_out_hrdata(ov_rdata), .err_count(ov_err), .dbg_state(ov_dbg)
  );

  logic           n1_hreadyout, n1_hresp;
  logic [DW-1:0]  n1_hrdata, n1_hwdata, n1_rdata;
  logic           n1_hsel, n1_hready, n1_hwrite, n1_rdy, n1_resp;
  logic [1:0]     n1_htrans, n1_dbg;
  logic [2:0]     n1_hsize;
  logic [AW-1:0]  n1_haddr;
  logic [7:0]     n1_err;

  ahb_fanout_n #(.N_PORTS(1), .ADDR_W(AW), .DATA_W(DW),
    .BASE(31'h0000_0000), .MASK(31'h7000_0000)) dut_n1 (
    .clock(clock), .reset(reset),
    .auto_in_hready(hready), .auto_in_htrans(htrans), .auto_in_hsize(hsize),
    .auto_in_hwrite(hwrite), .auto_in_haddr(haddr), .auto_in_hwdata(hwdata),
    .auto_in_hreadyout(n1_hreadyout), .auto_in_hresp(n1_hresp), .auto_in_hrdata(n1_hrdata),
    .auto_out_hsel(n1_hsel), .auto_out_hready(n1_hready), .auto_out_htrans(n1_htrans),
    .auto_out_hsize(n1_hsize), .auto_out_hwrite(n1_hwrite), .auto_out_haddr(n1_haddr),
    .auto_out_hwdata(n1_hwdata), .auto_out_hreadyout(n1_rdy), .auto_out_hresp(n1_resp),
    .auto_out_hrdata(n1_rdata), .err_count(n1_err), .dbg_state(n1_dbg)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: who owns the data phase, and the queued {hreadyout,hresp} pairs the
  // default slave still owes the master.
  int         m_owner;
  logic [1:0] exp_q[$];
  int         m_cnt;

  // Default map: 0x0/0x1/0x2 in the top nibble of the 31-bit address select ports 0..2.
  function automatic int ref_decode(input logic [AW-1:0] a);
    int region;
    region = int'(a[AW-1:AW-3]);
    return (region < NP) ? region : NP;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    exp_q.delete();
    m_cnt = 0;
  endtask

  task automatic model_resp(output logic r, output logic s, output logic [DW-1:0] d);
    r = 1'b1; s = 1'b0; d = '0;
    if (m_owner >= 0 && m_owner < NP) begin
      r = s_rdy[m_owner]; s = s_resp[m_owner]; d = s_rdata[m_owner*DW +: DW];
    end else if (m_owner == NP && exp_q.size() > 0) begin
      r = exp_q[0][1]; s = exp_q[0][0];
    end
  endtask

  task automatic model_advance();
    if (m_owner == NP && exp_q.size() > 0) void'(exp_q.pop_front());
    if (hready) begin
      if (!htrans[1]) m_owner = -1;
      else begin
        m_owner = ref_decode(haddr);
        if (m_owner == NP) begin
          exp_q.push_back(2'b01);
          exp_q.push_back(2'b11);
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  // Drives one address phase; hready follows the model's view of the current data phase.
  task automatic apply(input logic [1:0] t, input logic [AW-1:0] a);
    logic r, s;
    logic [DW-1:0] d;
    htrans = t; haddr = a;
    hwrite = 1'($urandom_range(0, 1)); hsize = 3'($urandom_range(0, 2)); hwdata = $urandom;
    model_resp(r, s, d);
    hready = r;
    #4;
  endtask

  task automatic finish_cycle();
    model_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; htrans = 2'b00; hready = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; htrans = 2'b00; hready = 1'b1; haddr = '0; hwrite = 1'b0; hsize = 3'd0;
    hwdata = '0; s_rdy = '1; s_resp = '0; s_rdata = {$urandom, $urandom, $urandom};
    ov_rdy = 2'b11; ov_resp = 2'b00; ov_rdata = {32'h2222_2222, 32'h1111_1111};
    n1_rdy = 1'b1; n1_resp = 1'b0; n1_rdata = 32'h0000_0111;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compared++; if (m_hreadyout !== 1'b1) begin mismatched++; $display("FAIL rst_rdy got=%b exp=1", m_hreadyout); end
    compared++; if (m_hresp !== 1'b0) begin mismatched++; $display("FAIL rst_resp got=%b exp=0", m_hresp); end
    compared++; if (m_hrdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata got=%h exp=0", m_hrdata); end
    compared++; if (m_err !== 8'h00) begin mismatched++; $display("FAIL rst_err got=%h exp=00", m_err); end
    reset = 1'b1;
  endtask

  task automatic test_read_port1();
    s_rdy = '1; s_resp = '0;
    s_rdata = {$urandom, 32'hCAFE_F00D, $urandom};
    apply(2'b10, 31'h1000_0040);
    compared++; if (o_hsel !== 3'b010) begin mismatched++; $display("FAIL rd_hsel got=%b exp=010", o_hsel); end
    compared++; if (o_htrans !== 6'b00_10_00) begin mismatched++; $display("FAIL rd_htrans got=%b exp=001000", o_htrans); end
    compared++; if (o_haddr !== {NP{31'h1000_0040}}) begin mismatched++; $display("FAIL rd_haddr got=%h", o_haddr); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if (m_hrdata !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL rd_data got=%h exp=cafef00d", m_hrdata); end
    compared++; if (m_hresp !== 1'b0) begin mismatched++; $display("FAIL rd_resp got=%b exp=0", m_hresp); end
    compared++; if (m_hreadyout !== 1'b1) begin mismatched++; $display("FAIL rd_rdy got=%b exp=1", m_hreadyout); end
    finish_cycle();
  endtask

  task automatic test_wait_states();
    int low;
    s_rdata[2*DW +: DW] = 32'h5A5A_0002;
    apply(2'b10, 31'h2000_0000);
    compared++; if (o_hsel !== 3'b100) begin mismatched++; $display("FAIL ws_hsel got=%b exp=100", o_hsel); end
    finish_cycle();
    s_rdy[2] = 1'b0;
    low = 0;
    for (int k = 0; k < 3; k++) begin
      apply(2'b10, 31'h3000_0000);
      if (m_hreadyout === 1'b0) low++;
      finish_cycle();
    end
    s_rdy[2] = 1'b1;
    apply(2'b00, '0);
    compared++; if (low != 3) begin mismatched++; $display("FAIL ws_low got=%0d exp=3", low); end
    compared++; if (m_hreadyout !== 1'b1) begin mismatched++; $display("FAIL ws_rdy got=%b exp=1", m_hreadyout); end
    compared++; if (m_hrdata !== 32'h5A5A_0002) begin mismatched++; $display("FAIL ws_data got=%h exp=5a5a0002", m_hrdata); end
    compared++; if (m_err !== 8'h00) begin mismatched++; $display("FAIL ws_err got=%h exp=00", m_err); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b10) begin mismatched++; $display("FAIL ws_after got=%b exp=10", {m_hreadyout, m_hresp}); end
    finish_cycle();
  endtask

  task automatic test_default_slave();
    apply(2'b10, 31'h3000_0000);
    compared++; if (o_hsel !== 3'b000) begin mismatched++; $display("FAIL ds_hsel got=%b exp=000", o_hsel); end
    compared++; if (o_htrans !== 6'b0) begin mismatched++; $display("FAIL ds_htrans got=%b exp=0", o_htrans); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b01) begin mismatched++; $display("FAIL ds_err1 got=%b exp=01", {m_hreadyout, m_hresp}); end
    compared++; if (m_hrdata !== 32'h0) begin mismatched++; $display("FAIL ds_data got=%h exp=0", m_hrdata); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b11) begin mismatched++; $display("FAIL ds_err2 got=%b exp=11", {m_hreadyout, m_hresp}); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b10) begin mismatched++; $display("FAIL ds_idle got=%b exp=10", {m_hreadyout, m_hresp}); end
    compared++; if (m_err !== 8'd1) begin mismatched++; $display("FAIL ds_cnt got=%0d exp=1", m_err); end
    finish_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(2'b10, 31'h3000_0000);
    finish_cycle();
    apply(2'b10, 31'h4000_0000);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b01) begin mismatched++; $display("FAIL bb_err1 got=%b exp=01", {m_hreadyout, m_hresp}); end
    finish_cycle();
    apply(2'b10, 31'h4000_0000);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b11) begin mismatched++; $display("FAIL bb_err2 got=%b exp=11", {m_hreadyout, m_hresp}); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if ({m_hreadyout, m_hresp} !== 2'b01) begin mismatched++; $display("FAIL bb_reerr1 got=%b exp=01", {m_hreadyout, m_hresp}); end
    compared++; if (m_err !== 8'd2) begin mismatched++; $display("FAIL bb_cnt got=%0d exp=2", m_err); end
    finish_cycle();
    for (int k = 0; k < 600; k++) begin
      apply(2'b10, {3'($urandom_range(3, 7)), 28'($urandom)});
      finish_cycle();
    end
    apply(2'b00, '0);
    compared++; if (m_err !== 8'hFF) begin mismatched++; $display("FAIL bb_sat got=%h exp=ff", m_err); end
    finish_cycle();
    repeat (3) begin apply(2'b00, '0); finish_cycle(); end
  endtask

  task automatic test_reset_in_err1();
    apply(2'b10, 31'h5000_0000);
    finish_cycle();
    s_rdata[0 +: DW] = 32'h0000_BEEF;
    apply(2'b00, '0);
    compared++; if (m_hreadyout !== 1'b0) begin mismatched++; $display("FAIL re_err1 got=%b exp=0", m_hreadyout); end
    #1 reset = 1'b0;
    #1;
    compared++; if ({m_hreadyout, m_hresp} !== 2'b10) begin mismatched++; $display("FAIL re_resp got=%b exp=10", {m_hreadyout, m_hresp}); end
    compared++; if (m_err !== 8'h00) begin mismatched++; $display("FAIL re_cnt got=%h exp=00", m_err); end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    apply(2'b10, 31'h0000_0010);
    compared++; if (o_hsel !== 3'b001) begin mismatched++; $display("FAIL re_hsel got=%b exp=001", o_hsel); end
    finish_cycle();
    apply(2'b00, '0);
    compared++; if (m_hrdata !== 32'h0000_BEEF) begin mismatched++; $display("FAIL re_data got=%h exp=0000beef", m_hrdata); end
    compared++; if ({m_hreadyout, m_hresp} !== 2'b10) begin mismatched++; $display("FAIL re_okay got=%b exp=10", {m_hreadyout, m_hresp}); end
    finish_cycle();
  endtask

  task automatic test_random();
    logic r, s;
    logic [DW-1:0] d;
    logic [NP-1:0] eh;
    logic [2*NP-1:0] et;
    int dec;
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < NP; p++) begin
        s_rdy[p]  = ($urandom_range(0, 3) != 0);
        s_resp[p] = ($urandom_range(0, 7) == 0);
        s_rdata[p*DW +: DW] = $urandom;
      end
      apply(2'($urandom_range(0, 3)), {3'($urandom_range(0, 5)), 28'($urandom)});
      dec = ref_decode(haddr);
      eh = '0; et = '0;
      if (htrans[1] && dec < NP) begin eh[dec] = 1'b1; et[2*dec +: 2] = htrans; end
      model_resp(r, s, d);
      compared++; if (o_hsel !== eh) begin mismatched++; $display("FAIL rnd_hsel k=%0d got=%b exp=%b", k, o_hsel, eh); end
      compared++; if (o_htrans !== et) begin mismatched++; $display("FAIL rnd_htrans k=%0d got=%b exp=%b", k, o_htrans, et); end
      compared++; if ({o_hready, o_hwrite, o_hsize, o_hwdata} !== {{NP{hready}}, {NP{hwrite}}, {NP{hsize}}, {NP{hwdata}}})
        begin mismatched++; $display("FAIL rnd_bcast k=%0d", k); end
      compared++; if ({m_hreadyout, m_hresp} !== {r, s}) begin mismatched++; $display("FAIL rnd_resp k=%0d got=%b exp=%b", k, {m_hreadyout, m_hresp}, {r, s}); end
      compared++; if (m_hrdata !== d) begin mismatched++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, m_hrdata, d); end
      compared++; if (m_err !== 8'(m_cnt)) begin mismatched++; $display("FAIL rnd_cnt k=%0d got=%0d exp=%0d", k, m_err, m_cnt); end
      finish_cycle();
    end
    for (int k = 0; k < 4; k++) begin apply(2'b00, '0); finish_cycle(); end
  endtask

  task automatic test_overlap_n1();
    do_reset();
    s_rdy = '1; s_resp = '0;
    apply(2'b10, 31'h1000_0040);
    compared++; if (ov_hsel !== 2'b01) begin mismatched++; $display("FAIL ov_hsel got=%b exp=01", ov_hsel); end
    compared++; if (n1_hsel !== 1'b0) begin mismatched++; $display("FAIL n1_miss got=%b exp=0", n1_hsel); end
    finish_cycle();
    apply(2'b10, 31'h0000_0100);
    compared++; if (ov_hrdata !== 32'h1111_1111) begin mismatched++; $display("FAIL ov_data got=%h exp=11111111", ov_hrdata); end
    compared++; if (n1_hsel !== 1'b1) begin mismatched++; $display("FAIL n1_hit got=%b exp=1", n1_hsel); end
    compared++; if ({n1_hreadyout, n1_hresp} !== 2'b01) begin mismatched++; $display("FAIL n1_err1 got=%b exp=01", {n1_hreadyout, n1_hresp}); end
    compared++; if (n1_err !== 8'd1) begin mismatched++; $display("FAIL n1_cnt got=%0d exp=1", n1_err); end
    finish_cycle();
    apply(2'b00, '0);
    finish_cycle();
  endtask

  initial begin
    test_reset();
    test_read_port1();
    test_wait_states();
    test_default_slave();
    test_back_to_back();
    test_reset_in_err1();
    test_random();
    test_overlap_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
